// File: rtl/scrolling_pkg.sv
// Shared types and constants for the scrolling display controller.
// Character format: bit4 = blank, bits[3:0] = hex digit.
package scrolling_pkg;

  localparam int CHAR_W = 5;
  localparam logic [CHAR_W-1:0] CHAR_BLANK = 5'h10;

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'd0,
    MODE_RIGHT  = 2'd1,
    MODE_STATIC = 2'd2,
    MODE_BLINK  = 2'd3
  } scroll_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIDE = 2'd2
  } scroll_state_t;

endpackage

// File: rtl/scrolling_tick_gen.sv
// Step-period tick generator: counts 0..step_top and ticks on step_top.
// A held clear keeps the count at zero and suppresses the tick.
module scrolling_tick_gen #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] step_top,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;

  assign tick = !clear && (cnt_q == step_top);

  // Period counter, wraps to zero on the tick or on clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/scrolling_display_ctrl.sv
// Scrolling display controller: character buffer, scroll window,
// blink control and registered digit outputs.
module scrolling_display_ctrl
  import scrolling_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int BUFFER_DEPTH = 16,
  parameter int CNT_W        = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [1:0]                         mode,
  input  logic [CNT_W-1:0]                   step_top,
  input  logic                               wr_en,
  input  logic [CHAR_W-1:0]                  wr_data,
  input  logic                               clr,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(BUFFER_DEPTH):0]      count,
  output logic                               overflow,
  output logic [N_DIGITS*CHAR_W-1:0]         digits,
  output logic                               step_pulse
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(BUFFER_DEPTH + N_DIGITS + 1);
  localparam int EW = LW + 1;
  localparam logic [EW-1:0] ND = EW'(N_DIGITS);

  scroll_state_t state_q, state_d;
  scroll_mode_t  mode_q, mode_w;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] ptr_q, ptr_d;
  logic [EW-1:0] len_q, len_d, idx;
  logic          vis_q, vis_d;
  logic          ovf_q, ovf_d;
  logic          pulse_q, pulse_d;
  logic [CHAR_W-1:0] ch;
  logic [N_DIGITS*CHAR_W-1:0] dig_q, dig_d;
  logic [CHAR_W-1:0] mem_q [BUFFER_DEPTH];

  logic tick, tclr, mchg, wr_acc;
  logic is_full, is_empty;

  assign mode_w   = scroll_mode_t'(mode);
  assign mchg     = (mode_w != mode_q);
  assign is_full  = (count_q == CW'(BUFFER_DEPTH));
  assign is_empty = (count_q == '0);
  assign wr_acc   = wr_en && !is_full && !clr;
  assign tclr     = (state_q == ST_IDLE) || clr || mchg;
  assign len_q    = EW'(count_q) + ND;

  scrolling_tick_gen #(
    .CNT_W(CNT_W)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (tclr),
    .step_top(step_top),
    .tick    (tick)
  );

  // Next-state for buffer, window pointer, FSM and the digit image.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    vis_d   = vis_q;
    ovf_d   = ovf_q;
    pulse_d = 1'b0;
    idx     = '0;
    ch      = CHAR_BLANK;

    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (wr_en) begin
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        tail_d  = tail_q + 1'b1;
        count_d = count_q + 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        ptr_d = '0;
        vis_d = 1'b1;
        if (enable && !is_empty && !clr) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (!enable || clr || is_empty) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
          vis_d   = 1'b1;
        end else if (mchg) begin
          state_d = ST_RUN;
          ptr_d   = '0;
          vis_d   = 1'b1;
        end else if (tick) begin
          unique case (mode_w)
            MODE_LEFT: begin
              ptr_d = (ptr_q + 1'b1 == len_q) ? '0 : ptr_q + 1'b1;
            end
            MODE_RIGHT: begin
              ptr_d = (ptr_q == '0) ? len_q - 1'b1 : ptr_q - 1'b1;
            end
            MODE_BLINK: begin
              vis_d   = !vis_q;
              state_d = vis_q ? ST_HIDE : ST_RUN;
            end
            default: ;
          endcase
          pulse_d = (mode_w != MODE_STATIC);
        end
      end
    endcase

    len_d = EW'(count_d) + ND;
    dig_d = {N_DIGITS{CHAR_BLANK}};
    if (state_d == ST_RUN) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        idx = ptr_d + EW'(i);
        if (idx >= len_d) idx = idx - len_d;
        if (idx < EW'(count_d)) begin
          if (wr_acc && idx == EW'(count_q)) ch = wr_data;
          else ch = mem_q[AW'(EW'(head_q) + idx)];
          dig_d[(N_DIGITS-1-i)*CHAR_W +: CHAR_W] = ch;
        end
      end
    end
  end

  // Character storage, contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[tail_q] <= wr_data;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LEFT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      vis_q   <= 1'b1;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      dig_q   <= {N_DIGITS{CHAR_BLANK}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_w;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      vis_q   <= vis_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      dig_q   <= dig_d;
    end
  end

  assign full       = is_full;
  assign empty      = is_empty;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign digits     = dig_q;
  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_scrolling_display_ctrl.sv
// Bench for scrolling_display_ctrl: directed scenarios plus random
// traffic against a queue-based behavioural model.
module tb_scrolling_display_ctrl;

  localparam int ND = 4;
  localparam int BD = 8;
  localparam int CW = 16;
  localparam logic [4:0] B = 5'h10;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    mode;
  logic [CW-1:0] step_top;
  logic          wr_en;
  logic [4:0]    wr_data;
  logic          clr;
  logic          full, empty, overflow, step_pulse;
  logic [3:0]    count;
  logic [ND*5-1:0] digits;

  int n_chk = 0;
  int n_err = 0;

  logic [4:0] q[$];
  int  m_ptr, m_cnt;
  bit  m_on, m_vis, m_ovf, m_pulse;
  logic [1:0] m_mprev;
  logic [4:0] v[8];

  always #5 clk = ~clk;

  scrolling_display_ctrl #(
    .N_DIGITS(ND), .BUFFER_DEPTH(BD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .step_top(step_top), .wr_en(wr_en), .wr_data(wr_data),
    .clr(clr), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .digits(digits), .step_pulse(step_pulse)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pk(logic [4:0] a, logic [4:0] b,
                                      logic [4:0] c, logic [4:0] d);
    return {a, b, c, d};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr = 0; m_cnt = 0;
    m_on = 0; m_vis = 1; m_ovf = 0; m_pulse = 0;
    m_mprev = 2'd0;
  endtask

  // One clock edge of the specified behaviour, using current inputs.
  task automatic model_edge();
    bit clear, tick, mchg;
    int L;
    mchg  = (mode != m_mprev);
    clear = !m_on || clr || mchg;
    tick  = !clear && (m_cnt == int'(step_top));
    m_cnt = (clear || tick) ? 0 : m_cnt + 1;
    m_pulse = 0;
    L = q.size() + ND;
    if (!m_on) begin
      m_ptr = 0; m_vis = 1;
      if (enable && q.size() > 0 && !clr) m_on = 1;
    end else if (!enable || clr || q.size() == 0) begin
      m_on = 0; m_vis = 1; m_ptr = 0;
    end else if (mchg) begin
      m_vis = 1; m_ptr = 0;
    end else if (tick) begin
      case (mode)
        2'd0: m_ptr = (m_ptr + 1) % L;
        2'd1: m_ptr = (m_ptr + L - 1) % L;
        2'd3: m_vis = !m_vis;
        default: ;
      endcase
      m_pulse = (mode != 2'd2);
    end
    if (clr) begin
      q.delete(); m_ovf = 0;
    end else if (wr_en) begin
      if (q.size() == BD) m_ovf = 1;
      else q.push_back(wr_data);
    end
    m_mprev = mode;
  endtask

  function automatic logic [19:0] exp_digits();
    logic [4:0] s[$];
    logic [19:0] r;
    int L;
    r = {4{B}};
    if (!m_on || !m_vis) return r;
    s = q;
    for (int k = 0; k < ND; k++) s.push_back(B);
    L = s.size();
    for (int i = 0; i < ND; i++) r[(ND-1-i)*5 +: 5] = s[(m_ptr + i) % L];
    return r;
  endfunction

  task automatic check_all(string tag);
    chk({tag, ".dig"}, 32'(digits), 32'(exp_digits()));
    chk({tag, ".cnt"}, 32'(count), 32'(q.size()));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == BD));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".pulse"}, 32'(step_pulse), 32'(m_pulse));
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic wr(logic [4:0] d);
    wr_en = 1'b1; wr_data = d;
    cyc("wr");
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; mode = 2'd0; step_top = 16'd3;
    wr_en = 1'b0; wr_data = 5'h0; clr = 1'b0;
    model_reset();
    #12;
    chk("rst.dig", 32'(digits), 32'(pk(B, B, B, B)));
    chk("rst.cnt", 32'(count), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);
    chk("rst.pulse", 32'(step_pulse), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Scroll left over 1,2,3 with L = 7.
    wr(5'h1); wr(5'h2); wr(5'h3);
    enable = 1'b1;
    cyc("l0");
    chk("left.first", 32'(digits), 32'(pk(5'h1, 5'h2, 5'h3, B)));
    repeat (3) cyc("l1");
    cyc("l2");
    chk("left.tick1", 32'(digits), 32'(pk(5'h2, 5'h3, B, B)));
    chk("left.pulse", 32'(step_pulse), 32'd1);
    repeat (24) cyc("l3");
    chk("left.wrap", 32'(digits), 32'(pk(5'h1, 5'h2, 5'h3, B)));

    // Scroll right.
    mode = 2'd1;
    cyc("r0");
    repeat (3) cyc("r1");
    cyc("r2");
    chk("right.tick1", 32'(digits), 32'(pk(B, 5'h1, 5'h2, 5'h3)));
    repeat (4) cyc("r3");
    chk("right.tick2", 32'(digits), 32'(pk(B, B, 5'h1, 5'h2)));

    // Mode change mid-scroll to static.
    mode = 2'd0;
    repeat (9) cyc("m0");
    mode = 2'd2;
    cyc("m1");
    chk("static.first", 32'(digits), 32'(pk(5'h1, 5'h2, 5'h3, B)));
    repeat (12) cyc("m2");
    chk("static.hold", 32'(digits), 32'(pk(5'h1, 5'h2, 5'h3, B)));

    // Fill, overflow, then clr beating a write.
    enable = 1'b0; clr = 1'b1;
    cyc("c0");
    clr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      v[k] = 5'($urandom_range(0, 15));
      wr(v[k]);
    end
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.cnt", 32'(count), 32'd8);
    wr(5'h7);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.cnt", 32'(count), 32'd8);
    enable = 1'b1;
    cyc("o1");
    chk("ovf.content", 32'(digits), 32'(pk(v[0], v[1], v[2], v[3])));
    clr = 1'b1; wr_en = 1'b1; wr_data = 5'h5;
    cyc("o2");
    clr = 1'b0; wr_en = 1'b0;
    chk("clr.cnt", 32'(count), 32'd0);
    chk("clr.ovf", 32'(overflow), 32'd0);
    chk("clr.empty", 32'(empty), 32'd1);
    chk("clr.dig", 32'(digits), 32'(pk(B, B, B, B)));

    // Blink every cycle.
    enable = 1'b0; mode = 2'd3; step_top = 16'd0;
    wr(5'hA); wr(5'hB);
    enable = 1'b1;
    cyc("b0");
    chk("blink.on", 32'(digits), 32'(pk(5'hA, 5'hB, B, B)));
    for (int k = 0; k < 6; k++) begin
      cyc("b1");
      chk("blink.dig", 32'(digits),
          (k % 2 == 0) ? 32'(pk(B, B, B, B)) : 32'(pk(5'hA, 5'hB, B, B)));
      chk("blink.pulse", 32'(step_pulse), 32'd1);
    end

    // Asynchronous reset mid-scroll.
    mode = 2'd0; step_top = 16'd1; wr(5'hC);
    repeat (5) cyc("a0");
    #2 rst = 1'b0;
    #1;
    chk("arst.dig", 32'(digits), 32'(pk(B, B, B, B)));
    chk("arst.cnt", 32'(count), 32'd0);
    chk("arst.empty", 32'(empty), 32'd1);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      clr = ($urandom_range(0, 99) < 3);
      if (clr) step_top = 16'($urandom_range(0, 3));
      wr_en = ($urandom_range(0, 99) < 15);
      wr_data = 5'($urandom);
      if ($urandom_range(0, 99) < 2) mode = 2'($urandom);
      enable = ($urandom_range(0, 99) < 95);
      cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
